linebuffer_ex: RTL and testbench
================================

Name: linebuffer_ex

Overview:
- Parametrised next-generation sprite line buffer: one buffer of DEPTH pixels, each {palette, colour index}.
- Write side: sprite renderer streams pixels at pixel rate.
- Write-side features: selectable increment/decrement (h-flip), transparent-pixel skip, out-of-range guard.
- Read side: video output fetches each pixel, then clears it to backdrop behind itself, so the buffer is ready for the next line with no separate clear pass.
- Sits between the sprite pixel pipeline and the palette RAM address mux.

Parameters:
- ADDR_W, 8: pointer width; pointer arithmetic is modulo 2^ADDR_W.
- DEPTH, 192: valid pixel locations 0..DEPTH-1; must be ≤ 2^ADDR_W.
- IDX_W, 4: colour index width.
- PAL_W, 8: palette number width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- CK_EN  in  1  pixel-rate enable; qualifies all write-side actions.
- WR_LOAD  in  1  with CK_EN: load write pointer from WR_ADDR.
- WR_ADDR  in  ADDR_W  start X for the sprite strip.
- WR_FLIP  in  1  0 = pointer +1 per pixel, 1 = pointer −1.
- WR_EN  in  1  with CK_EN: pixel present on COLOR_INDEX.
- COLOR_INDEX  in  IDX_W  pixel colour; 0 = transparent.
- PAL_EN  in  1  latch SPR_PAL.
- SPR_PAL  in  PAL_W  sprite palette number.
- RD_START  in  1  load read pointer from RD_ADDR; clear OVF.
- RD_ADDR  in  ADDR_W  read start X.
- RD_EN  in  1  request fetch-and-clear of the pixel at the read pointer.
- RD_BUSY  out  1  read FSM not idle.
- DATA_OUT  out  PAL_W+IDX_W  fetched pixel {pal, idx}.
- DATA_VALID  out  1  one-cycle strobe; DATA_OUT is new.
- OVF  out  1  sticky: a non-transparent write was attempted at pointer ≥ DEPTH.

Behaviour:
- Reset:
  - Write pointer, read pointer and PAL_REG = 0.
  - DATA_OUT = 0, DATA_VALID = 0, OVF = 0, RD_BUSY = 0, FSM = IDLE.
  - RAM contents are not reset.
- PAL_REG: on CLK, if PAL_EN then PAL_REG <= SPR_PAL.
- Write pointer WP:
  - On CK_EN & WR_LOAD: WP <= WR_ADDR. WR_LOAD has priority over WR_EN in the same cycle; no write occurs that cycle.
  - Else on CK_EN & WR_EN: WP <= WP ± 1, wrapping modulo 2^ADDR_W (255+1 = 0; 0−1 = 255).
- Write commit:
  - Port A writes {PAL_REG, COLOR_INDEX} to WP only when CK_EN & WR_EN & !WR_LOAD & COLOR_INDEX != 0 & WP < DEPTH.
  - The write uses WP before the increment.
- Transparent pixels (index 0) advance WP but write nothing.
- Overflow: CK_EN & WR_EN & COLOR_INDEX != 0 & WP ≥ DEPTH sets OVF. OVF clears only on RST or RD_START.
- Read FSM (port B), states IDLE → FETCH → CLEAR → IDLE:
  - IDLE: RD_START loads RP <= RD_ADDR and stays IDLE. RD_EN (RD_START low) issues a port-B read of RP and moves to FETCH.
  - FETCH: RAM data returns. DATA_OUT <= q and DATA_VALID = 1 in the next cycle. Move to CLEAR.
  - CLEAR: port B writes the all-ones backdrop to RP; RP <= RP + 1 (wraps). Move to IDLE.
  - Throughput: one pixel per 3 CLK. RD_EN while RD_BUSY is ignored, not queued.
- Read-pointer range: reads at RP ≥ DEPTH return all-ones and suppress the clear.
- RD_START while busy: takes effect on return to IDLE (held pending for one request), so the current fetch/clear always completes.
- Collision: if the port-A write and the port-B clear target the same address in the same cycle, the port-A sprite write wins and the clear is dropped.
- Latency: RD_EN (accepted in IDLE) to DATA_VALID = 2 cycles.
- Reset mid-operation returns the FSM to IDLE immediately. A partially cleared location is not guaranteed cleared.

Decomposition:
- Package lb_pkg holds:
  - read FSM state enum (IDLE, FETCH, CLEAR);
  - backdrop constant (all ones at PAL_W+IDX_W);
  - transparent index constant 0.
- Sub-module dpram #(ADDR_W, PAL_W+IDX_W): two ports, each registered-read with write enable.
- All control logic stays in linebuffer_ex.

Test Plan:
- Basic write/read: PAL_EN with SPR_PAL = 0x5A; WR_LOAD at 10, then 3 pixels idx 1,2,3 (FLIP = 0); RD_START at 10, three RD_EN → DATA_OUT 0x5A1, 0x5A2, 0x5A3, each 2 cycles after RD_EN.
- Clear-behind: after the reads above, re-read 10..12 → 0xFFF each.
- Flip and transparency: WR_LOAD 20, FLIP = 1, pixels idx 7,0,9 → addr 20 = {pal,7}, addr 19 = 0xFFF (untouched), addr 18 = {pal,9}.
- Wrap and overflow: WR_LOAD 190, FLIP = 0, four pixels idx 1 → addr 190 and 191 written; pointer 192/193 writes suppressed; OVF = 1; RD_START clears OVF.
- Collision: port-A write to addr 30 in the same cycle as the CLEAR of addr 30 → subsequent read of 30 returns the written pixel, not 0xFFF.
- Reset: assert RST during FETCH → RD_BUSY = 0, DATA_VALID = 0, OVF = 0 immediately; FSM accepts RD_EN in the first cycle after release.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared types and constants for the sprite line buffer.
// Holds the read FSM state encoding and the pixel code constants.
package lb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CLEAR = 2'd2
    } rd_state_e;

    // Colour index that marks a transparent pixel.
    localparam int unsigned TRANSP_IDX = 0;

    // Backdrop is all ones at any pixel width.
    localparam logic BACKDROP_BIT = 1'b1;

    // Backdrop at the default 8-bit palette / 4-bit index layout.
    localparam logic [11:0] BACKDROP = 12'hFFF;

endpackage

// File: rtl/linebuffer_ex_dpram.sv
// True dual-port RAM, registered reads, one write enable per port.
// Ports: CLK; a_we/a_addr/a_din/a_dout; b_we/b_addr/b_din/b_dout.
module dpram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12
) (
    input  logic              CLK,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-first on both ports; the caller avoids same-address
    // double writes, so write order here never matters.
    always_ff @(posedge CLK) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_we) begin
            mem[b_addr] <= b_din;
        end
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

endmodule

// File: rtl/linebuffer_ex.sv
// Sprite line buffer: pixel-rate sprite writes on port A, video
// fetch-and-clear on port B. Ports: CLK, RST; write side CK_EN,
// WR_LOAD, WR_ADDR, WR_FLIP, WR_EN, COLOR_INDEX, PAL_EN, SPR_PAL;
// read side RD_START, RD_ADDR, RD_EN, RD_BUSY, DATA_OUT,
// DATA_VALID; sticky overflow flag OVF.
module linebuffer_ex
    import lb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 192,
    parameter int IDX_W  = 4,
    parameter int PAL_W  = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CK_EN,
    input  logic                   WR_LOAD,
    input  logic [ADDR_W-1:0]      WR_ADDR,
    input  logic                   WR_FLIP,
    input  logic                   WR_EN,
    input  logic [IDX_W-1:0]       COLOR_INDEX,
    input  logic                   PAL_EN,
    input  logic [PAL_W-1:0]       SPR_PAL,
    input  logic                   RD_START,
    input  logic [ADDR_W-1:0]      RD_ADDR,
    input  logic                   RD_EN,
    output logic                   RD_BUSY,
    output logic [PAL_W+IDX_W-1:0] DATA_OUT,
    output logic                   DATA_VALID,
    output logic                   OVF
);

    localparam int PIX_W = PAL_W + IDX_W;

    localparam logic [ADDR_W:0] DEPTH_C =
        (ADDR_W+1)'(DEPTH);

    localparam logic [PIX_W-1:0] BACK_PIX =
        {PIX_W{BACKDROP_BIT}};

    localparam logic [IDX_W-1:0] TRANSP =
        IDX_W'(TRANSP_IDX);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    rd_state_e         state;
    rd_state_e         state_nx;

    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [PAL_W-1:0]  pal_reg;

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;

    logic              opaque;
    logic              wr_step;
    logic              wp_in;
    logic              rp_in;
    logic              a_we;
    logic              ovf_set;
    logic              hit;

    logic              start_now;
    logic [ADDR_W-1:0] start_addr;

    logic              b_we;
    logic              in_fetch;
    logic              in_clear;
    logic [PIX_W-1:0]  b_q;
    logic [PIX_W-1:0]  a_q_unused;

    // ---------------- write side ----------------

    assign opaque  = (COLOR_INDEX != TRANSP);
    assign wr_step = CK_EN & WR_EN & ~WR_LOAD;
    assign wp_in   = ({1'b0, wp} < DEPTH_C);
    assign a_we    = wr_step & opaque & wp_in;
    assign ovf_set = wr_step & opaque & ~wp_in;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pal_reg <= '0;
        end else if (PAL_EN) begin
            pal_reg <= SPR_PAL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp <= '0;
        end else if (CK_EN & WR_LOAD) begin
            wp <= WR_ADDR;
        end else if (wr_step) begin
            wp <= WR_FLIP ? wp - ONE : wp + ONE;
        end
    end

    // ---------------- read FSM ----------------

    assign rp_in = ({1'b0, rp} < DEPTH_C);

    // A sprite write landing on the address being cleared
    // keeps the sprite pixel.
    assign hit = a_we & (wp == rp);

    // A start seen during FETCH is parked; it (or a fresh
    // one arriving during CLEAR) takes over at CLEAR exit.
    assign start_now =
        ((state == IDLE) & RD_START) |
        ((state == CLEAR) & (RD_START | pend_vld));

    assign start_addr = RD_START ? RD_ADDR : pend_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (RD_EN & ~RD_START) begin
                    state_nx = FETCH;
                end
            end
            FETCH:   state_nx = CLEAR;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        RD_BUSY  = 1'b1;
        in_fetch = 1'b0;
        in_clear = 1'b0;
        b_we     = 1'b0;
        unique case (state)
            IDLE: begin
                RD_BUSY = 1'b0;
            end
            FETCH: begin
                in_fetch = 1'b1;
            end
            CLEAR: begin
                in_clear = 1'b1;
                b_we     = rp_in & ~hit;
            end
            default: begin
                RD_BUSY = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rp <= '0;
        end else if (start_now) begin
            rp <= start_addr;
        end else if (in_clear) begin
            rp <= rp + ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else if (start_now) begin
            pend_vld  <= 1'b0;
        end else if (in_fetch & RD_START) begin
            pend_vld  <= 1'b1;
            pend_addr <= RD_ADDR;
        end
    end

    // Out-of-range reads return backdrop instead of RAM data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= in_fetch;
            if (in_fetch) begin
                DATA_OUT <= rp_in ? b_q : BACK_PIX;
            end
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (ovf_set) begin
            OVF <= 1'b1;
        end else if (start_now) begin
            OVF <= 1'b0;
        end
    end

    dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .CLK    (CLK),
        .a_we   (a_we),
        .a_addr (wp),
        .a_din  ({pal_reg, COLOR_INDEX}),
        .a_dout (a_q_unused),
        .b_we   (b_we),
        .b_addr (rp),
        .b_din  (BACK_PIX),
        .b_dout (b_q)
    );

endmodule

// File: tb/tb_linebuffer_ex.sv
// Self-checking bench for linebuffer_ex.
// Table of directed ops plus hand-written corner sequences.
module tb_linebuffer_ex;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CK_EN = 1'b0;
    logic        WR_LOAD = 1'b0;
    logic [7:0]  WR_ADDR = '0;
    logic        WR_FLIP = 1'b0;
    logic        WR_EN = 1'b0;
    logic [3:0]  COLOR_INDEX = '0;
    logic        PAL_EN = 1'b0;
    logic [7:0]  SPR_PAL = '0;
    logic        RD_START = 1'b0;
    logic [7:0]  RD_ADDR = '0;
    logic        RD_EN = 1'b0;
    logic        RD_BUSY;
    logic [11:0] DATA_OUT;
    logic        DATA_VALID;
    logic        OVF;

    int n_tests = 0;
    int n_fail  = 0;

    linebuffer_ex dut (
        .CLK         (CLK),
        .RST         (RST),
        .CK_EN       (CK_EN),
        .WR_LOAD     (WR_LOAD),
        .WR_ADDR     (WR_ADDR),
        .WR_FLIP     (WR_FLIP),
        .WR_EN       (WR_EN),
        .COLOR_INDEX (COLOR_INDEX),
        .PAL_EN      (PAL_EN),
        .SPR_PAL     (SPR_PAL),
        .RD_START    (RD_START),
        .RD_ADDR     (RD_ADDR),
        .RD_EN       (RD_EN),
        .RD_BUSY     (RD_BUSY),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .OVF         (OVF)
    );

    always #5 CLK = ~CLK;

    typedef enum {
        OP_PAL, OP_LOAD, OP_PIX, OP_START,
        OP_READ, OP_DROP, OP_OVF
    } op_e;

    typedef struct {
        op_e         op;
        int          a;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(op_e o, int a, int e);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.exp = 12'(e);
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_pal(int p);
        PAL_EN  = 1'b1;
        SPR_PAL = 8'(p);
        tick();
        PAL_EN  = 1'b0;
    endtask

    task automatic wr_load(int a, int flip);
        CK_EN   = 1'b1;
        WR_LOAD = 1'b1;
        WR_ADDR = 8'(a);
        WR_FLIP = (flip != 0);
        tick();
        CK_EN   = 1'b0;
        WR_LOAD = 1'b0;
    endtask

    task automatic pix(int idx);
        CK_EN       = 1'b1;
        WR_EN       = 1'b1;
        COLOR_INDEX = 4'(idx);
        tick();
        CK_EN       = 1'b0;
        WR_EN       = 1'b0;
        COLOR_INDEX = '0;
    endtask

    task automatic rd_start(int a);
        RD_START = 1'b1;
        RD_ADDR  = 8'(a);
        tick();
        RD_START = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int budget = 10;
        while (RD_BUSY && budget > 0) begin
            tick();
            budget--;
        end
        if (RD_BUSY) begin
            chk({nm, " idle timeout"}, 1, 0);
        end
    endtask

    // Fetch one pixel; DATA_VALID must rise exactly two
    // edges after RD_EN is sampled.
    task automatic rd_pix(int exp, bit cmp, string nm);
        wait_idle(nm);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        if (cmp) begin
            chk({nm, " dv early"}, 32'(DATA_VALID), 0);
        end
        tick();
        if (cmp) begin
            chk({nm, " dv"}, 32'(DATA_VALID), 1);
            chk({nm, " data"}, 32'(DATA_OUT), exp);
        end
        tick();
        if (cmp) begin
            chk({nm, " dv drop"}, 32'(DATA_VALID), 0);
        end
    endtask

    initial begin
        string nm;

        tbl.push_back(mk(OP_PAL,   'h5A, 0));
        tbl.push_back(mk(OP_START, 18, 0));
        tbl.push_back(mk(OP_DROP,  0, 0));
        tbl.push_back(mk(OP_DROP,  0, 0));
        tbl.push_back(mk(OP_DROP,  0, 0));
        tbl.push_back(mk(OP_LOAD,  10, 0));
        tbl.push_back(mk(OP_PIX,   1, 0));
        tbl.push_back(mk(OP_PIX,   2, 0));
        tbl.push_back(mk(OP_PIX,   3, 0));
        tbl.push_back(mk(OP_START, 10, 0));
        tbl.push_back(mk(OP_READ,  0, 'h5A1));
        tbl.push_back(mk(OP_READ,  0, 'h5A2));
        tbl.push_back(mk(OP_READ,  0, 'h5A3));
        tbl.push_back(mk(OP_START, 10, 0));
        tbl.push_back(mk(OP_READ,  0, 'hFFF));
        tbl.push_back(mk(OP_READ,  0, 'hFFF));
        tbl.push_back(mk(OP_READ,  0, 'hFFF));
        tbl.push_back(mk(OP_LOAD,  20, 1));
        tbl.push_back(mk(OP_PIX,   7, 0));
        tbl.push_back(mk(OP_PIX,   0, 0));
        tbl.push_back(mk(OP_PIX,   9, 0));
        tbl.push_back(mk(OP_START, 18, 0));
        tbl.push_back(mk(OP_READ,  0, 'h5A9));
        tbl.push_back(mk(OP_READ,  0, 'hFFF));
        tbl.push_back(mk(OP_READ,  0, 'h5A7));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_LOAD,  190, 0));
        tbl.push_back(mk(OP_PIX,   1, 0));
        tbl.push_back(mk(OP_PIX,   1, 0));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_PIX,   1, 0));
        tbl.push_back(mk(OP_PIX,   1, 0));
        tbl.push_back(mk(OP_OVF,   0, 1));
        tbl.push_back(mk(OP_START, 190, 0));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_READ,  0, 'h5A1));
        tbl.push_back(mk(OP_READ,  0, 'h5A1));
        tbl.push_back(mk(OP_READ,  0, 'hFFF));
        tbl.push_back(mk(OP_LOAD,  255, 0));
        tbl.push_back(mk(OP_PIX,   0, 0));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_PIX,   5, 0));
        tbl.push_back(mk(OP_START, 0, 0));
        tbl.push_back(mk(OP_READ,  0, 'h5A5));
        tbl.push_back(mk(OP_LOAD,  0, 1));
        tbl.push_back(mk(OP_PIX,   0, 0));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_PIX,   3, 0));
        tbl.push_back(mk(OP_OVF,   0, 1));
        tbl.push_back(mk(OP_PAL,   'h33, 0));
        tbl.push_back(mk(OP_LOAD,  40, 0));
        tbl.push_back(mk(OP_PIX,   'hF, 0));
        tbl.push_back(mk(OP_START, 40, 0));
        tbl.push_back(mk(OP_OVF,   0, 0));
        tbl.push_back(mk(OP_READ,  0, 'h33F));

        // Reset state.
        RST = 1'b1;
        tick();
        tick();
        chk("rst busy", 32'(RD_BUSY), 0);
        chk("rst dv", 32'(DATA_VALID), 0);
        chk("rst data", 32'(DATA_OUT), 0);
        chk("rst ovf", 32'(OVF), 0);
        RST = 1'b0;
        tick();

        foreach (tbl[i]) begin
            nm = $sformatf("vec[%0d]", i);
            case (tbl[i].op)
                OP_PAL:   set_pal(tbl[i].a);
                OP_LOAD:  wr_load(tbl[i].a, int'(tbl[i].exp));
                OP_PIX:   pix(tbl[i].a);
                OP_START: rd_start(tbl[i].a);
                OP_READ:  rd_pix(int'(tbl[i].exp), 1'b1, nm);
                OP_DROP:  rd_pix(0, 1'b0, nm);
                OP_OVF:   chk({nm, " ovf"}, 32'(OVF),
                              int'(tbl[i].exp));
                default:  ;
            endcase
        end

        // RD_EN held while busy: only one fetch happens.
        wr_load(50, 0);
        pix(1);
        pix(2);
        rd_start(50);
        RD_EN = 1'b1;
        tick();
        tick();
        chk("hold dv", 32'(DATA_VALID), 1);
        chk("hold data", 32'(DATA_OUT), 'h331);
        tick();
        RD_EN = 1'b0;
        tick();
        chk("hold idle", 32'(RD_BUSY), 0);
        chk("hold no 2nd", 32'(DATA_VALID), 0);
        rd_pix('h332, 1'b1, "hold next");

        // RD_START during FETCH is applied after CLEAR.
        wr_load(60, 0);
        pix(4);
        pix(5);
        pix(6);
        rd_start(60);
        RD_EN = 1'b1;
        tick();
        RD_EN    = 1'b0;
        RD_START = 1'b1;
        RD_ADDR  = 8'd62;
        tick();
        RD_START = 1'b0;
        chk("pend dv", 32'(DATA_VALID), 1);
        chk("pend data", 32'(DATA_OUT), 'h334);
        tick();
        rd_pix('h336, 1'b1, "pend next");

        // Sprite write collides with the clear of addr 30.
        wr_load(30, 0);
        rd_start(30);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        tick();
        chk("coll in clear", 32'(RD_BUSY), 1);
        pix('hA);
        rd_start(30);
        rd_pix('h33A, 1'b1, "coll");

        // Reset in FETCH, then immediate restart.
        rd_start(30);
        wr_load(200, 0);
        pix(1);
        chk("ovf pre rst", 32'(OVF), 1);
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("busy pre rst", 32'(RD_BUSY), 1);
        RST = 1'b1;
        #1;
        chk("mid rst busy", 32'(RD_BUSY), 0);
        chk("mid rst dv", 32'(DATA_VALID), 0);
        chk("mid rst ovf", 32'(OVF), 0);
        tick();
        RST   = 1'b0;
        RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        chk("post rst accept", 32'(RD_BUSY), 1);
        tick();
        chk("post rst dv", 32'(DATA_VALID), 1);
        chk("post rst data", 32'(DATA_OUT), 'hFFF);
        tick();
        wr_load(70, 0);
        pix(1);
        rd_start(70);
        rd_pix('h001, 1'b1, "post rst pal");

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
